// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_if                                                      |
// | Fetch, data, memory and stall signals of the shared memory port arbiter. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   logic              stall_if;
   logic              stall_mem;

   // master: the arbiter itself; slave: the core/memory environment around it
   modport master (
      input  if_req, if_addr, if_flush,
      input  d_req, d_we, d_addr, d_wdata,
      input  m_ack, m_rdata,
      output if_rdata, if_valid, d_rdata, d_valid,
      output m_req, m_we, m_addr, m_wdata,
      output stall_if, stall_mem
   );

   modport slave (
      output if_req, if_addr, if_flush,
      output d_req, d_we, d_addr, d_wdata,
      output m_ack, m_rdata,
      input  if_rdata, if_valid, d_rdata, d_valid,
      input  m_req, m_we, m_addr, m_wdata,
      input  stall_if, stall_mem
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one single-ported memory between fetch and data access, one       |
// | transaction at a time. Optional fetch starvation guard:                  |
// | MEM_ARB_STARVE_GUARD_EN.                                                 |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  wire logic           clk,
   input  wire logic           rst,
   mem_port_arbiter_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_m_req;
   logic              r_m_we;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_valid;
   logic              r_d_valid;
   logic              r_cpl;
   logic              r_drop;
   logic              w_grant_d;
   logic              w_grant_f;
   logic              w_ack;
   logic              w_force_f;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_MAX);

   logic [2:0] r_starve;

   assign w_force_f = (r_starve == c_STARVE_MAX) && bus.if_req && !bus.if_flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= 3'd0;
      end else if (!bus.if_req || w_grant_f) begin
         r_starve <= 3'd0;
      end else if (w_grant_d && !bus.if_flush && (r_starve != 3'd7)) begin
         r_starve <= r_starve + 3'd1;
      end
   end
`else
   assign w_force_f = 1'b0;

   // The limit only matters to the guard; the counter could never reach beyond 7.
   if (STARVE_MAX > 7) begin : g_starve_max_unreachable
   end
`endif

   // The cycle after an ack never grants: requesters still show the old req until they see valid.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_d   = 1'b0;
      w_grant_f   = 1'b0;
      w_ack       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!r_cpl) begin
               if (bus.d_req && !w_force_f) begin
                  w_grant_d   = 1'b1;
                  w_state_nxt = DATA;
               end else if (bus.if_req && !bus.if_flush) begin
                  w_grant_f   = 1'b1;
                  w_state_nxt = FETCH;
               end
            end
         end
         FETCH, DATA: begin
            if (bus.m_ack) begin
               w_ack       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         r_cpl      <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         r_cpl      <= w_ack;

         if (w_grant_d) begin
            r_m_req   <= 1'b1;
            r_m_we    <= bus.d_we;
            r_m_addr  <= bus.d_addr;
            r_m_wdata <= bus.d_wdata;
         end else if (w_grant_f) begin
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= bus.if_addr;
            r_m_wdata <= '0;
         end else if (w_ack) begin
            r_m_req   <= 1'b0;
         end

         if (r_state == FETCH) begin
            if (w_ack) begin
               r_drop <= 1'b0;
               if (!(r_drop || bus.if_flush)) begin
                  r_if_valid <= 1'b1;
                  r_if_rdata <= bus.m_rdata;
               end
            end else if (bus.if_flush) begin
               r_drop <= 1'b1;
            end
         end

         if ((r_state == DATA) && w_ack) begin
            r_d_valid <= 1'b1;
            if (!r_m_we) begin
               r_d_rdata <= bus.m_rdata;
            end
         end
      end
   end

   assign bus.m_req     = r_m_req;
   assign bus.m_we      = r_m_we;
   assign bus.m_addr    = r_m_addr;
   assign bus.m_wdata   = r_m_wdata;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.if_valid  = r_if_valid;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.d_valid   = r_d_valid;
   assign bus.stall_if  = bus.if_req & ~r_if_valid;
   assign bus.stall_mem = bus.d_req & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Scoreboard bench: directed stimulus, memory responder, valid monitor.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   logic clk;
   logic rst;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_d_q[$];
   logic [31:0] mem[logic [31:0]];
   int          ack_delay;
   logic        ack_force;
   int          wcnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] rd(logic [31:0] a);
      logic [15:0] lo;
      lo = a[15:0];
      if (mem.exists(a)) return mem[a];
      return {16'hA5A5, lo};
   endfunction

   // Memory responder: ack after ack_delay extra cycles of m_req
   always @(negedge clk) begin
      if (!rst) begin
         bus.m_ack   = 1'b0;
         bus.m_rdata = 32'hBAD0_0000;
         wcnt        = 0;
      end else if (bus.m_req) begin
         if (wcnt >= ack_delay) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = rd(bus.m_addr);
            if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
            wcnt        = 0;
         end else begin
            bus.m_ack   = 1'b0;
            bus.m_rdata = 32'hBAD0_0000;
            wcnt++;
         end
      end else begin
         bus.m_ack   = ack_force;
         bus.m_rdata = 32'hBAD0_0001;
         wcnt        = 0;
      end
   end

   // Monitor: every valid pulse must match the next queued expectation
   always @(negedge clk) begin
      if (rst) begin
         if (bus.if_valid) begin
            if (exp_if_q.size() == 0) check("if_valid_unexpected", 64'(bus.if_rdata), 64'hDEAD);
            else check("if_rdata", 64'(bus.if_rdata), 64'(exp_if_q.pop_front()));
         end
         if (bus.d_valid) begin
            if (exp_d_q.size() == 0) check("d_valid_unexpected", 64'(bus.d_rdata), 64'hDEAD);
            else check("d_rdata", 64'(bus.d_rdata), 64'(exp_d_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int nd;
      int nf;
      int got;
      n_tests      = 0;
      n_fail       = 0;
      ack_delay    = 0;
      ack_force    = 1'b0;
      rst          = 1'b0;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.if_flush = 1'b0;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_addr   = '0;
      bus.d_wdata  = '0;
      bus.m_ack    = 1'b0;
      bus.m_rdata  = '0;
      mem[32'h40]  = 32'h2002_000A;
      mem[32'h44]  = 32'h2222_0044;
      mem[32'h100] = 32'h1111_0100;
      mem[32'h300] = 32'h3333_0300;
      mem[32'h50]  = 32'h4444_0050;

      repeat (3) tick();
      check("reset_ctrl", 64'({bus.m_req, bus.m_we, bus.if_valid, bus.d_valid}), 64'h0);
      check("reset_m_addr", 64'(bus.m_addr), 64'h0);
      check("reset_m_wdata", 64'(bus.m_wdata), 64'h0);
      check("reset_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
      rst = 1'b1;
      tick();

      // Single fetch, ack immediately
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      exp_if_q.push_back(32'h2002_000A);
      tick();
      check("fetch_c1_req_addr", {31'h0, bus.m_req, bus.m_addr}, {31'h0, 1'b1, 32'h40});
      check("fetch_c1_we_stall", 64'({bus.m_we, bus.stall_if}), 64'b01);
      tick();
      check("fetch_c2_valid_stall", 64'({bus.if_valid, bus.stall_if}), 64'b10);
      bus.if_req = 1'b0;
      tick();
      check("fetch_c3_idle", 64'({bus.m_req, bus.if_valid}), 64'h0);

      // Contention: data first, fetch after one dead cycle
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h44;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h100;
      exp_d_q.push_back(32'h1111_0100);
      exp_if_q.push_back(32'h2222_0044);
      tick();
      check("cont_c1_data_addr", 64'(bus.m_addr), 64'h100);
      tick();
      check("cont_c2_dvalid_stallif", 64'({bus.d_valid, bus.stall_if, bus.if_valid}), 64'b110);
      bus.d_req = 1'b0;
      tick();
      check("cont_c3_gap", 64'(bus.m_req), 64'h0);
      tick();
      check("cont_c4_fetch_addr", {31'h0, bus.m_req, bus.m_addr}, {31'h0, 1'b1, 32'h44});
      tick();
      check("cont_c5_if_valid", 64'(bus.if_valid), 64'h1);
      bus.if_req = 1'b0;
      tick();

      // Slow store: outputs held while waiting for ack
      ack_delay   = 2;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h200;
      bus.d_wdata = 32'hDEAD_BEEF;
      exp_d_q.push_back(32'h1111_0100);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("store_hold_c%0d", i),
               {bus.m_req, bus.m_we, bus.m_addr[29:0], bus.m_wdata},
               {1'b1, 1'b1, 30'h200, 32'hDEAD_BEEF});
         check($sformatf("store_novalid_c%0d", i), 64'(bus.d_valid), 64'h0);
      end
      tick();
      check("store_dvalid", 64'({bus.d_valid, bus.m_req, bus.stall_mem}), 64'b100);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      check("store_after", 64'(bus.d_valid), 64'h0);

      // Flush in the second fetch cycle; ack two cycles later
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h48;
      tick();
      check("flush_c1_req", 64'(bus.m_req), 64'h1);
      tick();
      bus.if_flush = 1'b1;
      tick();
      bus.if_flush = 1'b0;
      check("flush_c3_still_req", 64'(bus.m_req), 64'h1);
      tick();
      check("flush_c4_no_valid_idle", 64'({bus.if_valid, bus.m_req}), 64'h0);
      check("flush_c4_rdata_kept", 64'(bus.if_rdata), 64'h2222_0044);
      bus.if_req = 1'b0;
      tick();
      check("flush_c5_idle", 64'(bus.m_req), 64'h0);

      // Flush on the ack cycle itself
      ack_delay   = 0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h4C;
      tick();
      bus.if_flush = 1'b1;
      tick();
      bus.if_flush = 1'b0;
      check("flushack_no_valid", 64'({bus.if_valid, bus.m_req}), 64'h0);
      check("flushack_rdata_kept", 64'(bus.if_rdata), 64'h2222_0044);
      bus.if_req = 1'b0;
      tick();

      // Stray ack with no request outstanding
      ack_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stray_ack_%0d", i), 64'({bus.m_req, bus.if_valid, bus.d_valid}), 64'h0);
      end
      ack_force = 1'b0;
      tick();

      // Continuous data requests with a fetch waiting
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h300;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h50;
      nd = 0;
      nf = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      repeat (4) exp_d_q.push_back(32'h3333_0300);
      exp_if_q.push_back(32'h4444_0050);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.d_valid) nd++;
         if (bus.if_valid) begin
            nf = 1;
            break;
         end
      end
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      check("starve_fetch_granted", 64'(nf), 64'h1);
      check("starve_data_before_fetch", 64'(nd), 64'h4);
`else
      repeat (20) exp_d_q.push_back(32'h3333_0300);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.d_valid) nd++;
         if (bus.if_valid) nf++;
         if (nd == 20) break;
      end
      bus.d_req = 1'b0;
      check("strict_data_count", 64'(nd), 64'd20);
      check("strict_no_fetch", 64'(nf), 64'h0);
      exp_if_q.push_back(32'h4444_0050);
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.if_valid) begin
            got = i;
            break;
         end
      end
      bus.if_req = 1'b0;
      check("strict_fetch_after_data", 64'(got != 0), 64'h1);
`endif
      tick();
      tick();

      // Reset while a fetch waits for ack
      ack_delay   = 5;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h54;
      tick();
      check("rst_pre_req", 64'(bus.m_req), 64'h1);
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_ctrl", 64'({bus.m_req, bus.m_we, bus.if_valid, bus.d_valid}), 64'h0);
      check("rst_async_addr_wdata", {bus.m_addr, bus.m_wdata}, 64'h0);
      check("rst_async_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
      tick();
      tick();
      ack_delay = 0;
      rst       = 1'b1;
      exp_if_q.push_back(32'hA5A5_0054);
      got = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (bus.if_valid) begin
            got = i;
            break;
         end
      end
      bus.if_req = 1'b0;
      check("rst_recover_latency", 64'(got), 64'd2);
      tick();
      tick();

      check("sb_if_drained", 64'(exp_if_q.size()), 64'h0);
      check("sb_d_drained", 64'(exp_d_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
